// File: rtl/music_pkg.sv
// Shared types and constants for the note sequencer: FSM state encoding,
// note address width and the address of the first stored note.
package music_pkg;

  localparam int NOTE_ADDR_W = 4;
  localparam int TICK_W      = 8;

  // Address 0 is never written; stored notes live at 1..MAX_NOTES.
  localparam logic [NOTE_ADDR_W-1:0] FIRST_NOTE_ADDR = 4'd1;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    REC_PULSE = 4'd1,
    REC_GAP   = 4'd2,
    PLAY_LOAD = 4'd3,
    PLAY_WAIT = 4'd4,
    PLAY_SHOW = 4'd5,
    PLAY_HOLD = 4'd6,
    PLAY_GAP  = 4'd7,
    ERASE     = 4'd8
  } seq_state_t;

  function automatic logic is_play_state(input seq_state_t s);
    return s inside {PLAY_LOAD, PLAY_WAIT, PLAY_SHOW, PLAY_HOLD, PLAY_GAP};
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter; done flags the enabled cycle that consumes the last count.
// A load always wins over a decrement so a state entry restarts the count cleanly.
module tick_counter
  import music_pkg::*;
#(
  parameter int W = TICK_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         cnt_en,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = cnt_en && (cnt_q <= W'(1));

endmodule

// File: rtl/note_sequencer_ctrl.sv
// Record/playback sequencer for the 16-entry note memory.
// Define LOOP_PLAY_EN to restart playback from the first note at end-of-list.
module note_sequencer_ctrl
  import music_pkg::*;
#(
  parameter int NOTE_TICKS = 4,
  parameter int GAP_TICKS  = 1,
  parameter int READ_LAT   = 2,
  parameter int MAX_NOTES  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rec_key,
  input  logic                   play_req,
  input  logic                   stop_req,
  input  logic                   erase_req,
  input  logic                   tick,
  output logic                   ld_note,
  output logic                   ld_play,
  output logic [NOTE_ADDR_W-1:0] note_counter,
  output logic                   display_note,
  output logic                   clear,
  output logic                   audio_en,
  output logic                   playing,
  output logic [NOTE_ADDR_W-1:0] rec_count
);

  localparam logic [NOTE_ADDR_W-1:0] MAX_C = NOTE_ADDR_W'(MAX_NOTES);

  seq_state_t             state_q, state_d;
  logic [NOTE_ADDR_W-1:0] nc_q, nc_d;
  logic [NOTE_ADDR_W-1:0] rc_q, rc_d;
  logic                   ld_note_q, ld_note_d;
  logic                   ld_play_q, ld_play_d;
  logic                   disp_q, disp_d;
  logic                   clear_q, clear_d;
  logic                   audio_q, audio_d;
  logic                   playing_q, playing_d;
  logic                   step_next;

  logic              tc_load;
  logic [TICK_W-1:0] tc_load_val;
  logic              tc_en;
  logic              tc_done;

  // PLAY_WAIT counts clk cycles; HOLD and GAP count tempo ticks.
  assign tc_en   = (state_q == PLAY_WAIT) ? 1'b1 : tick;
  assign tc_load = (state_d != state_q);

  always_comb begin
    case (state_d)
      PLAY_WAIT: tc_load_val = TICK_W'(READ_LAT);
      PLAY_HOLD: tc_load_val = TICK_W'(NOTE_TICKS);
      PLAY_GAP:  tc_load_val = TICK_W'(GAP_TICKS);
      default:   tc_load_val = '0;
    endcase
  end

  tick_counter #(.W(TICK_W)) u_tick_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (tc_load),
    .load_val (tc_load_val),
    .cnt_en   (tc_en),
    .done     (tc_done)
  );

  always_comb begin
    state_d   = state_q;
    nc_d      = nc_q;
    rc_d      = rc_q;
    clear_d   = 1'b0;
    step_next = 1'b0;

    case (state_q)
      IDLE: begin
        if (erase_req) begin
          state_d = ERASE;
        end else if (play_req && (rc_q != '0)) begin
          state_d = PLAY_LOAD;
          nc_d    = FIRST_NOTE_ADDR;
        end else if (rec_key && (rc_q < MAX_C)) begin
          state_d = REC_PULSE;
        end
      end
      REC_PULSE: begin
        state_d = REC_GAP;
        rc_d    = rc_q + 1'b1;
      end
      REC_GAP:   state_d = IDLE;
      PLAY_LOAD: state_d = (READ_LAT == 0) ? PLAY_SHOW : PLAY_WAIT;
      PLAY_WAIT: if (tc_done) state_d = PLAY_SHOW;
      PLAY_SHOW: state_d = PLAY_HOLD;
      PLAY_HOLD: begin
        if (tc_done) begin
          if (GAP_TICKS == 0) step_next = 1'b1;
          else                state_d   = PLAY_GAP;
        end
      end
      PLAY_GAP: if (tc_done) step_next = 1'b1;
      ERASE: begin
        rc_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (step_next) begin
      if (nc_q < rc_q) begin
        nc_d    = nc_q + 1'b1;
        state_d = PLAY_LOAD;
      end else begin
`ifdef LOOP_PLAY_EN
        nc_d    = FIRST_NOTE_ADDR;
        state_d = PLAY_LOAD;
`else
        state_d = IDLE;
        clear_d = 1'b1;
`endif
      end
    end

    // Stop overrides everything else, including the end-of-list step.
    if (stop_req && is_play_state(state_q)) begin
      state_d = IDLE;
      nc_d    = nc_q;
      clear_d = 1'b1;
    end

    if (state_d == ERASE) clear_d = 1'b1;

    ld_note_d = (state_d == REC_PULSE);
    ld_play_d = (state_d == PLAY_LOAD);
    disp_d    = (state_d == PLAY_SHOW);
    audio_d   = (state_d == PLAY_HOLD);
    playing_d = is_play_state(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      nc_q      <= '0;
      rc_q      <= '0;
      ld_note_q <= 1'b0;
      ld_play_q <= 1'b0;
      disp_q    <= 1'b0;
      clear_q   <= 1'b0;
      audio_q   <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nc_q      <= nc_d;
      rc_q      <= rc_d;
      ld_note_q <= ld_note_d;
      ld_play_q <= ld_play_d;
      disp_q    <= disp_d;
      clear_q   <= clear_d;
      audio_q   <= audio_d;
      playing_q <= playing_d;
    end
  end

  assign ld_note      = ld_note_q;
  assign ld_play      = ld_play_q;
  assign note_counter = nc_q;
  assign display_note = disp_q;
  assign clear        = clear_q;
  assign audio_en     = audio_q;
  assign playing      = playing_q;
  assign rec_count    = rc_q;

endmodule

// File: tb/tb_note_sequencer_ctrl.sv
// Directed bench for note_sequencer_ctrl: a per-cycle vector table for the
// record/erase basics plus hand-written playback, stop, saturation and reset sequences.
module tb_note_sequencer_ctrl;

  logic       clk = 1'b0;
  logic       reset, rec_key, play_req, stop_req, erase_req, tick;
  logic       ld_note, ld_play, display_note, clear, audio_en, playing;
  logic [3:0] note_counter, rec_count;

  note_sequencer_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .rec_key      (rec_key),
    .play_req     (play_req),
    .stop_req     (stop_req),
    .erase_req    (erase_req),
    .tick         (tick),
    .ld_note      (ld_note),
    .ld_play      (ld_play),
    .note_counter (note_counter),
    .display_note (display_note),
    .clear        (clear),
    .audio_en     (audio_en),
    .playing      (playing),
    .rec_count    (rec_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Event monitor, sampled mid-cycle.
  logic mon_en  = 1'b0;
  logic mon_clr = 1'b0;
  int   cyc, n_audio_ticks, n_audio_rise, n_ldnote, n_clear;
  int   play_nc[$];
  int   play_cyc[$];
  int   disp_cyc[$];
  logic audio_prev;

  always @(negedge clk) begin
    if (mon_clr) begin
      cyc = 0; n_audio_ticks = 0; n_audio_rise = 0; n_ldnote = 0; n_clear = 0;
      play_nc.delete(); play_cyc.delete(); disp_cyc.delete();
      audio_prev = 1'b0;
    end else if (mon_en) begin
      cyc++;
      if (ld_play) begin
        play_nc.push_back(int'(note_counter));
        play_cyc.push_back(cyc);
      end
      if (display_note) disp_cyc.push_back(cyc);
      if (audio_en && tick) n_audio_ticks++;
      if (audio_en && !audio_prev) n_audio_rise++;
      audio_prev = audio_en;
      if (ld_note) n_ldnote++;
      if (clear) n_clear++;
    end
  end

  task automatic mon_restart();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
    mon_en  = 1'b1;
  endtask

  task automatic rec_note();
    rec_key = 1'b1;
    step();
    rec_key = 1'b0;
    step();
    step();
  endtask

  typedef struct {
    logic rec, play, stop, erase;
    logic e_ldnote, e_ldplay, e_clear, e_playing;
    int   e_nc, e_rc;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, p, s, e, input logic ln, lp, cl, pl, input int nc, rc);
    vec_t v;
    v.rec = r; v.play = p; v.stop = s; v.erase = e;
    v.e_ldnote = ln; v.e_ldplay = lp; v.e_clear = cl; v.e_playing = pl;
    v.e_nc = nc; v.e_rc = rc;
    vt.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   rec play stop erase | ldn ldp clr ply nc rc
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 0, 0, 0, 0);   // play with no notes ignored
    add(0, 0, 1, 0,  0, 0, 0, 0, 0, 0);   // stop in IDLE ignored
    add(1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0,  1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0,  0, 0, 0, 0, 0, 2);   // rec during REC_PULSE ignored
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0,  1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
    add(0, 1, 0, 1,  0, 0, 1, 0, 0, 3);   // erase beats play
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 0, 0, 0, 0);

    reset = 1'b1; rec_key = 1'b0; play_req = 1'b0; stop_req = 1'b0;
    erase_req = 1'b0; tick = 1'b0;
    step(); step();
    chk("reset_outputs", int'({ld_note, ld_play, display_note, clear, audio_en, playing}), 0);
    chk("reset_nc", int'(note_counter), 0);
    chk("reset_rc", int'(rec_count), 0);
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      rec_key = vt[i].rec; play_req = vt[i].play; stop_req = vt[i].stop; erase_req = vt[i].erase;
      step();
      chk($sformatf("vec%0d_ld_note", i), int'(ld_note), int'(vt[i].e_ldnote));
      chk($sformatf("vec%0d_ld_play", i), int'(ld_play), int'(vt[i].e_ldplay));
      chk($sformatf("vec%0d_clear", i), int'(clear), int'(vt[i].e_clear));
      chk($sformatf("vec%0d_playing", i), int'(playing), int'(vt[i].e_playing));
      chk($sformatf("vec%0d_nc", i), int'(note_counter), vt[i].e_nc);
      chk($sformatf("vec%0d_rc", i), int'(rec_count), vt[i].e_rc);
    end
    rec_key = 1'b0; play_req = 1'b0; stop_req = 1'b0; erase_req = 1'b0;

`ifdef LOOP_PLAY_EN
    rec_note(); rec_note();
    chk("rec2_count", int'(rec_count), 2);
    mon_restart();
    play_req = 1'b1; step(); play_req = 1'b0;
    for (int k = 0; k < 150; k++) begin
      tick = (k % 3 == 2);
      step();
    end
    tick = 1'b0;
    chk("loop_playing", int'(playing), 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("loop_nc%0d", i), (i < play_nc.size()) ? play_nc[i] : -1, (i % 2) + 1);
    stop_req = 1'b1; step(); stop_req = 1'b0;
    chk("loop_stop_playing", int'(playing), 0);
    erase_req = 1'b1; step(); erase_req = 1'b0; step();
    rec_note();
`else
    rec_note(); rec_note(); rec_note();
    chk("rec3_count", int'(rec_count), 3);
    mon_restart();
    play_req = 1'b1; step(); play_req = 1'b0;
    for (int k = 0; k < 400 && playing; k++) begin
      tick = (k % 3 == 2);
      step();
    end
    tick = 1'b0;
    step();
    chk("play_end_playing", int'(playing), 0);
    chk("play_ld_count", play_nc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("play_nc%0d", i), (i < play_nc.size()) ? play_nc[i] : -1, i + 1);
      chk($sformatf("disp_lat%0d", i),
          (i < play_nc.size() && i < disp_cyc.size()) ? disp_cyc[i] - play_cyc[i] : -1, 3);
    end
    chk("audio_ticks", n_audio_ticks, 12);
    chk("audio_notes", n_audio_rise, 3);
    chk("end_clear_pulses", n_clear, 1);
`endif

    // stop during the first note's HOLD
    play_req = 1'b1; step(); play_req = 1'b0;
    for (int k = 0; k < 20 && !audio_en; k++) step();
    chk("stop_reached_hold", int'(audio_en), 1);
    stop_req = 1'b1; step(); stop_req = 1'b0;
    chk("stop_playing", int'(playing), 0);
    chk("stop_audio", int'(audio_en), 0);
    chk("stop_ld_play", int'(ld_play), 0);
    chk("stop_clear", int'(clear), 1);
    chk("stop_nc_hold", int'(note_counter), 1);
    step();
    chk("stop_clear_one_cycle", int'(clear), 0);

    // saturation at 15 notes
    erase_req = 1'b1; step(); erase_req = 1'b0; step();
    chk("erase_rc", int'(rec_count), 0);
    mon_restart();
    for (int i = 0; i < 16; i++) rec_note();
    chk("sat_ld_note_pulses", n_ldnote, 15);
    chk("sat_rc", int'(rec_count), 15);
    mon_en = 1'b0;

    // reset during PLAY_WAIT
    play_req = 1'b1; step(); play_req = 1'b0;
    chk("rst_pre_ld_play", int'(ld_play), 1);
    step();
    chk("rst_pre_wait", int'({ld_play, playing}), 1);
    reset = 1'b1; step();
    chk("rst_mid_outputs", int'({ld_note, ld_play, display_note, clear, audio_en, playing}), 0);
    chk("rst_mid_nc", int'(note_counter), 0);
    chk("rst_mid_rc", int'(rec_count), 0);
    reset = 1'b0; step();
    chk("rst_after_playing", int'(playing), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
